// File: rtl/mem_resp_stage.sv
// mem_resp_stage: memory-access stage sitting between EX and WB.
// Holds one instruction at a time. If that instruction issued a data-SRAM request,
// the stage stalls until the matching data_ok arrives. A response that arrives while
// WB is blocked is captured in a buffer. Load data is aligned and extended before
// writeback. Responses still owed to instructions flushed by wb_ex are dropped.
//
// Ports:
//   clk, resetn           clock; asynchronous active-low reset
//   es_*                  instruction handed over from EX (valid/allowin handshake)
//   data_sram_data_ok     one in-order response per accepted request
//   data_sram_rdata       read data, valid with data_ok
//   ws_allowin, wb_ex     WB backpressure and exception/ertn flush
//   ms_*                  instruction presented to WB, plus forwarding and busy status
module mem_resp_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned EX_W        = 81,
  parameter int unsigned EX_FLAG_BIT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [31:0]       es_pc,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic              es_res_from_mem,
  input  logic              es_mem_req,
  input  logic              es_req_inflight,
  input  logic [6:0]        es_ld_op,
  input  logic              es_rf_we,
  input  logic [4:0]        es_rf_waddr,
  input  logic [EX_W-1:0]   es_ex_zip,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              ws_allowin,
  input  logic              wb_ex,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic              ms_rf_we,
  output logic [4:0]        ms_rf_waddr,
  output logic [DATA_W-1:0] ms_rf_wdata,
  output logic [EX_W-1:0]   ms_ex_zip,
  output logic              ms_ex,
  output logic              ms_fwd_valid,
  output logic              ms_busy
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);

  logic              ms_valid_q, ms_valid_d;
  logic              resp_got_q, resp_got_d;
  logic [1:0]        cancel_cnt_q, cancel_cnt_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] alu_q;
  logic              res_from_mem_q, mem_req_q, rf_we_q;
  logic [6:0]        ld_op_q;
  logic [4:0]        rf_waddr_q;
  logic [EX_W-1:0]   ex_zip_q;

  logic              resp_live, ms_ready_go, load_en, leave;
  logic              owed_inc, inflight_inc, cancel_dec;
  logic [DATA_W-1:0] load_src, shifted, load_result;

  // A response counts for the current instruction only once every response owed to
  // flushed instructions has been drained.
  assign resp_live = data_sram_data_ok & (cancel_cnt_q == 2'd0) & ms_valid_q & mem_req_q
                   & ~resp_got_q;
  assign ms_ready_go    = ~mem_req_q | resp_got_q | resp_live;
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign load_en        = es_to_ms_valid & ms_allowin & ~wb_ex;
  assign leave          = ms_to_ws_valid & ws_allowin;

  // On a flush, the MS instruction still owes a response unless it arrives this cycle;
  // the EX instruction owes one if its request is outstanding.
  assign owed_inc     = wb_ex & ms_valid_q & mem_req_q & ~resp_got_q & ~resp_live;
  assign inflight_inc = wb_ex & es_req_inflight;
  assign cancel_dec   = data_sram_data_ok & (cancel_cnt_q != 2'd0);

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (wb_ex) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end

    resp_got_d  = resp_got_q;
    rdata_buf_d = rdata_buf_q;
    if (wb_ex || leave) begin
      resp_got_d = 1'b0;
    end else if (resp_live && !ws_allowin) begin
      resp_got_d = 1'b1;
    end
    if (resp_live && !ws_allowin) begin
      rdata_buf_d = data_sram_rdata;
    end

    cancel_cnt_d = cancel_cnt_q + 2'(owed_inc) + 2'(inflight_inc) - 2'(cancel_dec);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q     <= 1'b0;
      resp_got_q     <= 1'b0;
      cancel_cnt_q   <= 2'd0;
      rdata_buf_q    <= '0;
      pc_q           <= '0;
      alu_q          <= '0;
      res_from_mem_q <= 1'b0;
      mem_req_q      <= 1'b0;
      ld_op_q        <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      ex_zip_q       <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      resp_got_q   <= resp_got_d;
      cancel_cnt_q <= cancel_cnt_d;
      rdata_buf_q  <= rdata_buf_d;
      if (load_en) begin
        pc_q           <= es_pc;
        alu_q          <= es_alu_result;
        res_from_mem_q <= es_res_from_mem;
        mem_req_q      <= es_mem_req;
        ld_op_q        <= es_ld_op;
        rf_we_q        <= es_rf_we;
        rf_waddr_q     <= es_rf_waddr;
        ex_zip_q       <= es_ex_zip;
      end
    end
  end

  // A buffered response takes precedence; otherwise the live bus data passes straight
  // through so a response accepted by WB in its arrival cycle costs no extra cycle.
  assign load_src = resp_got_q ? rdata_buf_q : data_sram_rdata;
  assign shifted  = load_src >> {alu_q[OffW-1:0], 3'b000};

  // ld_op bit order: {b, bu, h, hu, w, wu, d}. On a 32-bit datapath the w/wu/d casts are
  // all identity, so wu and d fall out as w.
  always_comb begin
    load_result = shifted;
    if (ld_op_q[6]) begin
      load_result = DATA_W'($signed(shifted[7:0]));
    end else if (ld_op_q[5]) begin
      load_result = DATA_W'(shifted[7:0]);
    end else if (ld_op_q[4]) begin
      load_result = DATA_W'($signed(shifted[15:0]));
    end else if (ld_op_q[3]) begin
      load_result = DATA_W'(shifted[15:0]);
    end else if (ld_op_q[2]) begin
      load_result = DATA_W'($signed(shifted[31:0]));
    end else if (ld_op_q[1]) begin
      load_result = DATA_W'(shifted[31:0]);
    end else if (ld_op_q[0]) begin
      load_result = shifted;
    end
  end

  assign ms_pc        = pc_q;
  assign ms_rf_we     = ms_valid_q & rf_we_q;
  assign ms_rf_waddr  = rf_waddr_q;
  assign ms_rf_wdata  = res_from_mem_q ? load_result : alu_q;
  assign ms_ex_zip    = ex_zip_q;
  assign ms_ex        = ms_valid_q & ex_zip_q[EX_FLAG_BIT];
  assign ms_fwd_valid = ms_valid_q & rf_we_q & ms_ready_go;
  assign ms_busy      = ms_valid_q & ~ms_ready_go;

endmodule

// File: tb/tb_mem_resp_stage.sv
module tb_mem_resp_stage;

  localparam logic [6:0] LdB  = 7'b1000000;
  localparam logic [6:0] LdBu = 7'b0100000;
  localparam logic [6:0] LdH  = 7'b0010000;
  localparam logic [6:0] LdHu = 7'b0001000;
  localparam logic [6:0] LdW  = 7'b0000100;
  localparam logic [6:0] LdWu = 7'b0000010;
  localparam logic [6:0] LdD  = 7'b0000001;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [63:0] alu64;
  logic        es_res_from_mem, es_mem_req, es_req_inflight;
  logic [6:0]  es_ld_op;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [80:0] es_ex_zip;
  logic        data_ok;
  logic [63:0] rdata64;
  logic        ws_allowin, wb_ex;

  logic        a32_allowin, a32_to_ws, a32_rf_we, a32_ex, a32_fwd, a32_busy;
  logic [31:0] a32_pc, a32_wdata;
  logic [4:0]  a32_waddr;
  logic [80:0] a32_zip;
  logic        a64_allowin, a64_to_ws, a64_rf_we, a64_ex, a64_fwd, a64_busy;
  logic [31:0] a64_pc;
  logic [63:0] a64_wdata;
  logic [4:0]  a64_waddr;
  logic [80:0] a64_zip;

  mem_resp_stage #(.DATA_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(a32_allowin),
    .es_pc(es_pc), .es_alu_result(alu64[31:0]), .es_res_from_mem(es_res_from_mem),
    .es_mem_req(es_mem_req), .es_req_inflight(es_req_inflight), .es_ld_op(es_ld_op),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_ex_zip(es_ex_zip),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64[31:0]), .ws_allowin(ws_allowin),
    .wb_ex(wb_ex), .ms_to_ws_valid(a32_to_ws), .ms_pc(a32_pc), .ms_rf_we(a32_rf_we),
    .ms_rf_waddr(a32_waddr), .ms_rf_wdata(a32_wdata), .ms_ex_zip(a32_zip), .ms_ex(a32_ex),
    .ms_fwd_valid(a32_fwd), .ms_busy(a32_busy)
  );

  mem_resp_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(a64_allowin),
    .es_pc(es_pc), .es_alu_result(alu64), .es_res_from_mem(es_res_from_mem),
    .es_mem_req(es_mem_req), .es_req_inflight(es_req_inflight), .es_ld_op(es_ld_op),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_ex_zip(es_ex_zip),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64), .ws_allowin(ws_allowin),
    .wb_ex(wb_ex), .ms_to_ws_valid(a64_to_ws), .ms_pc(a64_pc), .ms_rf_we(a64_rf_we),
    .ms_rf_waddr(a64_waddr), .ms_rf_wdata(a64_wdata), .ms_ex_zip(a64_zip), .ms_ex(a64_ex),
    .ms_fwd_valid(a64_fwd), .ms_busy(a64_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [80:0] zip;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   use64    = 1'b0;

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic act_to_ws();
    return use64 ? a64_to_ws : a32_to_ws;
  endfunction
  function automatic logic act_busy();
    return use64 ? a64_busy : a32_busy;
  endfunction
  function automatic logic [63:0] act_wdata();
    return use64 ? a64_wdata : {32'h0, a32_wdata};
  endfunction
  function automatic logic [1:0] act_cancel();
    return use64 ? dut64.cancel_cnt_q : dut32.cancel_cnt_q;
  endfunction
  function automatic logic act_valid();
    return use64 ? dut64.ms_valid_q : dut32.ms_valid_q;
  endfunction

  // Scoreboard monitor: every MS->WB transfer pops the oldest expected instruction.
  always @(negedge clk) begin
    if (resetn && !wb_ex && ws_allowin && act_to_ws()) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xfer: got pc 0x%0h expected no transfer",
                 use64 ? a64_pc : a32_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("xfer_pc", 81'(use64 ? a64_pc : a32_pc), 81'(e.pc));
        chk("xfer_rf_we", 81'(use64 ? a64_rf_we : a32_rf_we), 81'(e.rf_we));
        chk("xfer_waddr", 81'(use64 ? a64_waddr : a32_waddr), 81'(e.waddr));
        chk("xfer_wdata", 81'(act_wdata()), 81'(e.wdata));
        chk("xfer_zip", use64 ? a64_zip : a32_zip, e.zip);
        chk("xfer_ex", 81'(use64 ? a64_ex : a32_ex), 81'(e.zip[1]));
      end
    end
  end

  // The cancel counter must never exceed 2.
  always @(negedge clk) begin
    if (resetn) begin
      assert (dut32.cancel_cnt_q <= 2'd2 && dut64.cancel_cnt_q <= 2'd2)
      else begin
        failures++;
        $display("FAIL cancel_bound: got %0d/%0d required <=2",
                 dut32.cancel_cnt_q, dut64.cancel_cnt_q);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_ms_valid  = 1'b0;
    es_pc           = '0;
    alu64           = '0;
    es_res_from_mem = 1'b0;
    es_mem_req      = 1'b0;
    es_req_inflight = 1'b0;
    es_ld_op        = '0;
    es_rf_we        = 1'b0;
    es_rf_waddr     = '0;
    es_ex_zip       = '0;
    data_ok         = 1'b0;
    wb_ex           = 1'b0;
  endtask

  // Present one instruction from EX, wait (bounded) for acceptance, and optionally
  // record what WB must later receive.
  task automatic issue(input logic [31:0] pc, input logic [63:0] alu, input logic [6:0] op,
                       input logic rfm, input logic mreq, input logic we,
                       input logic [4:0] wa, input logic exf, input logic push,
                       input logic [63:0] exp_wdata);
    exp_t e;
    bit   ok;
    es_to_ms_valid  = 1'b1;
    es_pc           = pc;
    alu64           = alu;
    es_ld_op        = op;
    es_res_from_mem = rfm;
    es_mem_req      = mreq;
    es_rf_we        = we;
    es_rf_waddr     = wa;
    es_ex_zip       = {pc, 49'h0};
    es_ex_zip[1]    = exf;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (use64 ? a64_allowin : a32_allowin) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: got allowin 0 expected 1 within 20 cycles");
    end
    if (push) begin
      e.pc    = pc;
      e.rf_we = we;
      e.waddr = wa;
      e.wdata = exp_wdata;
      e.zip   = es_ex_zip;
      sb_q.push_back(e);
    end
    step();
    es_to_ms_valid = 1'b0;
    es_mem_req     = 1'b0;
  endtask

  // Full memory instruction with the response arriving lat cycles after acceptance.
  task automatic do_mem(input logic [31:0] pc, input logic [63:0] alu, input logic [6:0] op,
                        input logic rfm, input logic we, input logic [4:0] wa,
                        input logic [63:0] rdata, input int lat, input logic [63:0] exp_w);
    issue(pc, alu, op, rfm, 1'b1, we, wa, 1'b0, 1'b1, exp_w);
    for (int i = 0; i < lat; i++) begin
      chk("busy_wait", 81'(act_busy()), 81'(1));
      chk("no_out_wait", 81'(act_to_ws()), 81'(0));
      step();
    end
    data_ok = 1'b1;
    rdata64 = rdata;
    #1;
    chk("ready_on_ok", 81'(act_to_ws()), 81'(1));
    chk("busy_on_ok", 81'(act_busy()), 81'(0));
    step();
    data_ok = 1'b0;
    rdata64 = 64'hA5A5_A5A5_A5A5_A5A5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    idle();
    rdata64    = '0;
    ws_allowin = 1'b1;
    resetn     = 1'b0;
    step();
    step();
    chk("rst_to_ws", 81'(a32_to_ws), 81'(0));
    chk("rst_busy", 81'(a32_busy), 81'(0));
    chk("rst_pc", 81'(a32_pc), 81'(0));
    chk("rst_wdata", 81'(a32_wdata), 81'(0));
    chk("rst_cancel", 81'(dut32.cancel_cnt_q), 81'(0));
    resetn = 1'b1;
    step();

    // 32-bit load extraction.
    do_mem(32'h100, 64'h1003, LdB, 1'b1, 1'b1, 5'd5, 64'h80FF_1234, 3, 64'hFFFF_FF80);
    do_mem(32'h104, 64'h1002, LdHu, 1'b1, 1'b1, 5'd6, 64'hBEEF_0000, 1, 64'h0000_BEEF);
    do_mem(32'h108, 64'h1002, LdH, 1'b1, 1'b1, 5'd7, 64'hBEEF_0000, 0, 64'hFFFF_BEEF);
    do_mem(32'h10C, 64'h1001, LdBu, 1'b1, 1'b1, 5'd8, 64'h0000_9A00, 2, 64'h0000_009A);
    do_mem(32'h110, 64'h1000, LdW, 1'b1, 1'b1, 5'd9, 64'h8000_0001, 1, 64'h8000_0001);
    do_mem(32'h114, 64'h1000, LdWu, 1'b1, 1'b1, 5'd10, 64'h8000_0001, 0, 64'h8000_0001);
    // Store: waits for data_ok, writeback value is the address.
    do_mem(32'h118, 64'h2004, 7'b0, 1'b0, 1'b0, 5'd0, 64'hFFFF_FFFF, 1, 64'h2004);

    // Non-memory instruction carrying an exception flag.
    issue(32'h11C, 64'h55AA, 7'b0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 1'b1, 64'h55AA);
    chk("alu_ex", 81'(a32_ex), 81'(1));
    chk("alu_fwd", 81'(a32_fwd), 81'(1));
    chk("alu_busy", 81'(a32_busy), 81'(0));
    step();

    // Response buffered while WB is blocked, bus data changes afterwards.
    issue(32'h200, 64'h2000, LdW, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b1, 64'h1234_5678);
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    rdata64    = 64'h1234_5678;
    #1;
    chk("buf_ready", 81'(a32_to_ws), 81'(1));
    step();
    data_ok = 1'b0;
    rdata64 = 64'hDEAD_BEEF;
    #1;
    chk("buf_hold1", 81'(a32_wdata), 81'(32'h1234_5678));
    chk("buf_valid", 81'(a32_to_ws), 81'(1));
    step();
    ws_allowin = 1'b1;
    #1;
    chk("buf_hold2", 81'(a32_wdata), 81'(32'h1234_5678));
    step();

    // Flush in WAIT with another request in flight: two responses must be dropped.
    issue(32'h400, 64'h3000, LdW, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0, 64'h0);
    wb_ex           = 1'b1;
    es_req_inflight = 1'b1;
    step();
    wb_ex           = 1'b0;
    es_req_inflight = 1'b0;
    chk("flush_cancel2", 81'(dut32.cancel_cnt_q), 81'(2));
    chk("flush_valid", 81'(dut32.ms_valid_q), 81'(0));
    issue(32'h500, 64'h3004, LdW, 1'b1, 1'b1, 1'b1, 5'd14, 1'b0, 1'b1, 64'hCAFE_F00D);
    data_ok = 1'b1;
    rdata64 = 64'h1111_1111;
    #1;
    chk("drop1_out", 81'(a32_to_ws), 81'(0));
    chk("drop1_busy", 81'(a32_busy), 81'(1));
    step();
    rdata64 = 64'h2222_2222;
    #1;
    chk("drop2_cancel", 81'(dut32.cancel_cnt_q), 81'(1));
    chk("drop2_out", 81'(a32_to_ws), 81'(0));
    step();
    rdata64 = 64'hCAFE_F00D;
    #1;
    chk("live_cancel", 81'(dut32.cancel_cnt_q), 81'(0));
    chk("live_out", 81'(a32_to_ws), 81'(1));
    step();
    data_ok = 1'b0;

    // Flush coincident with the response: nothing left owed.
    issue(32'h600, 64'h3008, LdW, 1'b1, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 64'h0);
    data_ok = 1'b1;
    wb_ex   = 1'b1;
    rdata64 = 64'h7777_7777;
    step();
    data_ok = 1'b0;
    wb_ex   = 1'b0;
    chk("coin_cancel", 81'(dut32.cancel_cnt_q), 81'(0));
    chk("coin_valid", 81'(dut32.ms_valid_q), 81'(0));

    // Reset in WAIT with a pending cancel drops everything.
    wb_ex           = 1'b1;
    es_req_inflight = 1'b1;
    step();
    wb_ex           = 1'b0;
    es_req_inflight = 1'b0;
    chk("pre_rst_cancel", 81'(dut32.cancel_cnt_q), 81'(1));
    issue(32'h700, 64'h300C, LdW, 1'b1, 1'b1, 1'b1, 5'd16, 1'b0, 1'b0, 64'h0);
    chk("pre_rst_busy", 81'(a32_busy), 81'(1));
    resetn = 1'b0;
    #1;
    chk("rst_wait_valid", 81'(dut32.ms_valid_q), 81'(0));
    chk("rst_wait_to_ws", 81'(a32_to_ws), 81'(0));
    chk("rst_wait_busy", 81'(a32_busy), 81'(0));
    chk("rst_wait_cancel", 81'(dut32.cancel_cnt_q), 81'(0));
    step();
    resetn = 1'b1;
    step();
    do_mem(32'h800, 64'h1000, LdB, 1'b1, 1'b1, 5'd17, 64'h0000_007F, 2, 64'h0000_007F);

    // 64-bit datapath.
    use64  = 1'b1;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    chk("rst64_cancel", 81'(act_cancel()), 81'(0));
    chk("rst64_valid", 81'(act_valid()), 81'(0));
    do_mem(32'h900, 64'h1004, LdWu, 1'b1, 1'b1, 5'd1, 64'h8765_4321_0000_0000, 1,
           64'h0000_0000_8765_4321);
    do_mem(32'h904, 64'h1004, LdW, 1'b1, 1'b1, 5'd2, 64'h8765_4321_0000_0000, 0,
           64'hFFFF_FFFF_8765_4321);
    do_mem(32'h908, 64'h1008, LdD, 1'b1, 1'b1, 5'd3, 64'h8765_4321_0000_0000, 2,
           64'h8765_4321_0000_0000);
    do_mem(32'h90C, 64'h1007, LdB, 1'b1, 1'b1, 5'd4, 64'h8765_4321_0000_0000, 1,
           64'hFFFF_FFFF_FFFF_FF87);
    do_mem(32'h910, 64'h1006, LdHu, 1'b1, 1'b1, 5'd5, 64'h8765_4321_0000_0000, 1,
           64'h0000_0000_0000_8765);
    step();
    step();

    chk("sb_drained", 81'(sb_q.size()), 81'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
